// File: rtl/stage_decode_pkg.sv
// Shared types for the decode stage: RV32I opcodes, ALU operations, immediate
// formats and the decoded control bundle carried in ID/EX.
package stage_decode_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          STAGES    = 1;

    typedef enum logic [6:0] {
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // All-zero value is the bubble (alu_op zero encodes ALU_ADD).
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        alu_op_t    alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // reg_op distinguishes OP (funct7[5] selects SUB) from OP-IMM (ADDI never SUB).
    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt, input logic reg_op);
        case (f3)
            3'd0:    alu_sel = (alt && reg_op) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_sel = ALU_SLL;
            3'd2:    alu_sel = ALU_SLT;
            3'd3:    alu_sel = ALU_SLTU;
            3'd4:    alu_sel = ALU_XOR;
            3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/stage_decode_if.sv
// Fetch-to-decode handshake: instruction/PC from fetch, stall back to fetch.
interface stage_decode_if #(
    parameter int XLEN = 32
) ();
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            stall_if;

    modport master (output if_valid, if_instr, if_pc, input stall_if);
    modport slave  (input if_valid, if_instr, if_pc, output stall_if);
endinterface

// File: rtl/stage_decode_imm_gen.sv
// RV32I immediate extraction; opcode bits are not needed, only the format.
module stage_decode_imm_gen
    import stage_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);
    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (imm_type)
            IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   raw = {instr[31:12], 12'b0};
            IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign imm = XLEN'(signed'(raw));
endmodule

// File: rtl/stage_decode.sv
// Decode stage: IF/ID register, RV32I decode, load-use interlock and ID/EX register.
module stage_decode #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = stage_decode_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    stage_decode_if.slave              fetch,
    input  logic                       flush,
    input  logic                       ex_stall,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [4:0]                 id_rs1,
    output logic [4:0]                 id_rs2,
    output logic [4:0]                 id_rd,
    output logic [XLEN-1:0]            id_imm,
    output stage_decode_pkg::alu_op_t  id_alu_op,
    output logic [2:0]                 id_funct3,
    output logic                       id_reg_write,
    output logic                       id_mem_read,
    output logic                       id_mem_write,
    output logic                       id_branch,
    output logic                       id_jump,
    output logic                       id_illegal
);
    import stage_decode_pkg::*;

    // vld_pipe[0]: IF/ID valid, vld_pipe[1]: ID/EX valid
    logic [STAGES:0] vld_pipe;
    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    ctrl_t           idex;
    logic [XLEN-1:0] idex_imm;
    logic [XLEN-1:0] idex_pc;

    ctrl_t           dec;
    imm_type_e       imm_type;
    logic [XLEN-1:0] dec_imm;
    opcode_e         opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            use_rs1, use_rs2, use_rd, legal;
    logic            hazard;

    always_comb begin
        dec      = '0;
        imm_type = IMM_NONE;
        opc      = opcode_e'(ifid_instr[6:0]);
        f3       = ifid_instr[14:12];
        f7       = ifid_instr[31:25];
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        legal    = 1'b1;
        case (opc)
            OP: begin
                {use_rs1, use_rs2, use_rd, dec.reg_write} = 4'b1111;
                legal      = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                dec.alu_op = alu_sel(f3, f7[5], 1'b1);
            end
            OP_IMM: begin
                {use_rs1, use_rd, dec.reg_write} = 3'b111;
                imm_type   = IMM_I;
                dec.alu_op = alu_sel(f3, f7[5], 1'b0);
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            end
            LOAD: begin
                {use_rs1, use_rd, dec.reg_write, dec.mem_read} = 4'b1111;
                imm_type = IMM_I;
                legal    = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            STORE: begin
                {use_rs1, use_rs2, dec.mem_write} = 3'b111;
                imm_type = IMM_S;
                legal    = (f3 <= 3'd2);
            end
            BRANCH: begin
                {use_rs1, use_rs2, dec.branch} = 3'b111;
                imm_type   = IMM_B;
                dec.alu_op = ALU_SUB;
                legal      = (f3 != 3'd2) && (f3 != 3'd3);
            end
            JAL: begin
                {use_rd, dec.reg_write, dec.jump} = 3'b111;
                imm_type = IMM_J;
            end
            JALR: begin
                {use_rs1, use_rd, dec.reg_write, dec.jump} = 4'b1111;
                imm_type = IMM_I;
                legal    = (f3 == 3'd0);
            end
            LUI: begin
                {use_rd, dec.reg_write} = 2'b11;
                imm_type   = IMM_U;
                dec.alu_op = ALU_PASS_B;
            end
            AUIPC: begin
                {use_rd, dec.reg_write} = 2'b11;
                imm_type = IMM_U;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            imm_type    = IMM_NONE;
        end else begin
            dec.rs1 = use_rs1 ? ifid_instr[19:15] : 5'd0;
            dec.rs2 = use_rs2 ? ifid_instr[24:20] : 5'd0;
            dec.rd  = use_rd  ? ifid_instr[11:7]  : 5'd0;
        end
        dec.funct3 = f3;

        if (!vld_pipe[0]) begin
            dec      = '0;
            imm_type = IMM_NONE;
        end
    end

    stage_decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (ifid_instr[31:7]),
        .imm_type (imm_type),
        .imm      (dec_imm)
    );

    // Unused sources are already forced to 0, and rd==0 is excluded, so x0 never interlocks.
    assign hazard = vld_pipe[1] && idex.mem_read && (idex.rd != 5'd0) && vld_pipe[0] &&
                    ((dec.rs1 == idex.rd) || (dec.rs2 == idex.rd));

    // Gated by rst_n so fetch is released the moment reset asserts, even with ex_stall high.
    assign fetch.stall_if = rst_n && !flush && (ex_stall || hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            idex       <= '0;
            idex_imm   <= '0;
            idex_pc    <= '0;
        end else if (flush) begin
            vld_pipe   <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            idex       <= '0;
            idex_imm   <= '0;
            idex_pc    <= '0;
        end else if (!ex_stall) begin
            if (hazard) begin
                vld_pipe[1] <= 1'b0;
                idex        <= '0;
                idex_imm    <= '0;
                idex_pc     <= '0;
            end else begin
                vld_pipe   <= {vld_pipe[0], fetch.if_valid};
                ifid_instr <= fetch.if_instr;
                ifid_pc    <= fetch.if_pc;
                idex       <= dec;
                idex_imm   <= dec_imm;
                idex_pc    <= vld_pipe[0] ? ifid_pc : '0;
            end
        end
    end

    assign id_valid     = vld_pipe[1];
    assign id_pc        = idex_pc;
    assign id_rs1       = idex.rs1;
    assign id_rs2       = idex.rs2;
    assign id_rd        = idex.rd;
    assign id_imm       = idex_imm;
    assign id_alu_op    = idex.alu_op;
    assign id_funct3    = idex.funct3;
    assign id_reg_write = idex.reg_write;
    assign id_mem_read  = idex.mem_read;
    assign id_mem_write = idex.mem_write;
    assign id_branch    = idex.branch;
    assign id_jump      = idex.jump;
    assign id_illegal   = idex.illegal;
endmodule

// File: tb/tb_stage_decode.sv
// Directed bench for stage_decode with an instruction-level reference model.
module tb_stage_decode;
    import stage_decode_pkg::*;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic ex_stall = 1'b0;
    always #5 clk = ~clk;

    stage_decode_if #(.XLEN(XLEN)) fe ();

    logic            id_valid, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal;
    logic [XLEN-1:0] id_pc, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    alu_op_t         id_alu_op;

    stage_decode #(.XLEN(XLEN), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fe), .flush(flush), .ex_stall(ex_stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        rw, mr, mw, br, jp, ill;
    } exp_t;

    int nchecks = 0;
    int nerr = 0;
    logic chk_on = 1'b0;

    // Reference decode straight from the ISA tables.
    function automatic exp_t mdecode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [31:0] sx;
        logic [2:0] f3;
        logic [6:0] f7;
        logic legal;
        logic [3:0] tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        sx = {32{ins[31]}};
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        legal = 1'b1;
        case (ins[6:0])
            7'h33: begin
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.rw = 1;
                e.alu = tbl[f3];
                if (f7[5] && f3 == 0) e.alu = ALU_SUB;
                if (f7[5] && f3 == 5) e.alu = ALU_SRA;
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h13: begin
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rw = 1;
                e.imm = (sx << 12) | 32'(ins[31:20]);
                e.alu = tbl[f3];
                if (f7[5] && f3 == 5) e.alu = ALU_SRA;
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) legal = ((f7 & 7'h5F) == 0);
            end
            7'h03: begin
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rw = 1; e.mr = 1;
                e.imm = (sx << 12) | 32'(ins[31:20]);
                legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.mw = 1;
                e.imm = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
                legal = (f3 < 3);
            end
            7'h63: begin
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.br = 1; e.alu = ALU_SUB;
                e.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                legal = !(f3 inside {3'd2, 3'd3});
            end
            7'h6F: begin
                e.rd = ins[11:7]; e.rw = 1; e.jp = 1;
                e.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'h67: begin
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rw = 1; e.jp = 1;
                e.imm = (sx << 12) | 32'(ins[31:20]);
                legal = (f3 == 0);
            end
            7'h37: begin e.rd = ins[11:7]; e.rw = 1; e.imm = ins & 32'hFFFF_F000; e.alu = ALU_PASS_B; end
            7'h17: begin e.rd = ins[11:7]; e.rw = 1; e.imm = ins & 32'hFFFF_F000; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e = '0;
            e.ill = 1;
        end
        e.valid = 1;
        e.pc = pc;
        e.f3 = f3;
        return e;
    endfunction

    logic        m_ifv;
    logic [31:0] m_ifi, m_ifp;
    exp_t        m_ex;

    function automatic logic m_hazard();
        exp_t d;
        d = mdecode(m_ifi, m_ifp);
        return m_ex.valid && m_ex.mr && m_ex.rd != 0 && m_ifv && (d.rs1 == m_ex.rd || d.rs2 == m_ex.rd);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ifv <= 0; m_ifi <= 32'h13; m_ifp <= 0; m_ex <= '0;
        end else if (flush) begin
            m_ifv <= 0; m_ifi <= 32'h13; m_ifp <= 0; m_ex <= '0;
        end else if (!ex_stall) begin
            if (m_hazard()) m_ex <= '0;
            else begin
                m_ifv <= fe.if_valid; m_ifi <= fe.if_instr; m_ifp <= fe.if_pc;
                m_ex  <= m_ifv ? mdecode(m_ifi, m_ifp) : '0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            exp_t act;
            logic exp_stall;
            act = '{id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_alu_op, id_funct3,
                    id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal};
            nchecks++;
            if (act !== m_ex) begin
                nerr++;
                $display("FAIL idex t=%0t got %h expected %h", $time, act, m_ex);
            end
            exp_stall = rst_n && !flush && (ex_stall || m_hazard());
            nchecks++;
            if (fe.stall_if !== exp_stall) begin
                nerr++;
                $display("FAIL stall_if t=%0t got %b expected %b", $time, fe.stall_if, exp_stall);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic st);
        fe.if_valid = v; fe.if_instr = ins; fe.if_pc = pc; flush = fl; ex_stall = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093, LW = 32'h0000_A103, ADD = 32'h0011_01B3;
    localparam logic [31:0] BEQ = 32'hFE00_0CE3, LUI_I = 32'h1234_52B7, SUB = 32'h4011_0233;
    localparam logic [31:0] SRAI = 32'h4030_D293, SW = 32'h0020_A223, JAL_I = 32'h0100_00EF;

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 32'h0, 32'h0, 0, 0);
        #8;
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_stall", 32'(fe.stall_if), 0);
        chk("rst_alu", 32'(id_alu_op), 32'(ALU_ADD));
        chk("rst_ctrl", 32'({id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal}), 0);
        #9;
        rst_n = 1'b1;
        chk_on = 1'b1;

        drive(1, ADDI, 32'h100, 0, 0); tick();
        drive(0, 32'hDEAD_BEEF, 32'h0, 0, 0); tick();
        chk("addi_valid", 32'(id_valid), 1);
        chk("addi_rd", 32'(id_rd), 1);
        chk("addi_rs1", 32'(id_rs1), 0);
        chk("addi_imm", id_imm, 5);
        chk("addi_alu", 32'(id_alu_op), 32'(ALU_ADD));
        chk("addi_rw", 32'(id_reg_write), 1);

        drive(1, LW, 32'h104, 0, 0); tick();
        drive(1, ADD, 32'h108, 0, 0); tick();
        chk("lu_stall", 32'(fe.stall_if), 1);
        chk("lw_rd", 32'(id_rd), 2);
        tick();
        chk("lu_bubble", 32'(id_valid), 0);
        chk("lu_release", 32'(fe.stall_if), 0);
        drive(1, BEQ, 32'h10C, 0, 0); tick();
        chk("add_regs", {17'b0, id_rs1, id_rs2, id_rd}, {17'b0, 5'd2, 5'd1, 5'd3});
        drive(1, LUI_I, 32'h110, 0, 0); tick();
        chk("beq_imm", id_imm, 32'hFFFF_FFF8);
        chk("beq_ctl", 32'({id_branch, id_reg_write, id_rd}), 32'({1'b1, 1'b0, 5'd0}));
        drive(1, SUB, 32'h114, 0, 0); tick();
        chk("lui_imm", id_imm, 32'h1234_5000);
        chk("lui_rs1", 32'(id_rs1), 0);
        drive(1, SRAI, 32'h118, 0, 0); tick();
        chk("sub_alu", 32'(id_alu_op), 32'(ALU_SUB));
        drive(1, SW, 32'h11C, 0, 0); tick();
        chk("srai_alu", 32'(id_alu_op), 32'(ALU_SRA));
        drive(1, JAL_I, 32'h120, 0, 0); tick();
        chk("sw_imm", id_imm, 4);
        drive(1, 32'hFFFF_FFFF, 32'h124, 0, 0); tick();
        chk("jal_imm", id_imm, 16);
        drive(0, 32'h0, 32'h0, 0, 0); tick();
        chk("ill_flags", 32'({id_valid, id_illegal}), 3);
        chk("ill_ctl", 32'({id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump}), 0);

        drive(1, LW, 32'h200, 0, 0); tick();
        drive(1, ADD, 32'h204, 0, 0); tick();
        chk("fl_pre_stall", 32'(fe.stall_if), 1);
        drive(1, ADD, 32'h204, 1, 1); #1;
        chk("fl_stall", 32'(fe.stall_if), 0);
        tick();
        chk("fl_idvalid", 32'(id_valid), 0);
        drive(0, 32'h0, 32'h0, 0, 0); tick();
        chk("fl_ifid_dead", 32'(id_valid), 0);

        drive(1, LUI_I, 32'h300, 0, 0); tick();
        drive(1, ADDI, 32'h304, 0, 0); tick();
        drive(1, BEQ, 32'h308, 0, 1); #1;
        chk("st_stall0", 32'(fe.stall_if), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_pc", id_pc, 32'h300);
            chk("st_stall", 32'(fe.stall_if), 1);
        end
        drive(1, BEQ, 32'h308, 0, 0); tick();
        chk("st_ifid_held", id_pc, 32'h304);
        drive(1, SW, 32'h30C, 0, 1); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(id_valid), 0);
        chk("rst_mid_stall", 32'(fe.stall_if), 0);
        chk("rst_mid_pc", id_pc, 0);
        chk("rst_mid_imm", id_imm, 0);
        #1 rst_n = 1'b1;
        drive(1, ADDI, 32'h400, 0, 0); tick();
        drive(0, 32'h0, 32'h0, 0, 0); tick();
        chk("post_rst", id_pc, 32'h400);
        tick(); tick();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/stage_decode.md
Name: stage_decode

Overview:
- Pipeline stage directly downstream of the fetch stage.
- Registers each fetched instruction/PC pair (IF/ID), decodes RV32I fields, control and immediate, and registers the result into ID/EX.
- Detects load-use hazards against the instruction currently in EX, and drives the stall back to fetch.
- Register file read is external; this block exports rs1/rs2 addresses.

Parameters:
XLEN, 32, datapath/PC/immediate width
NOP_INSTR, 32'h00000013, instruction loaded into IF/ID on reset/flush (addi x0,x0,0)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents a valid instruction
if_instr  in  32  fetched instruction
if_pc  in  XLEN  PC of if_instr
flush  in  1  kill IF/ID and ID/EX contents (branch/jump redirect)
ex_stall  in  1  downstream cannot accept; hold both registers
stall_if  out  1  to fetch: hold PC and instruction
id_valid  out  1  ID/EX entry valid
id_pc  out  XLEN  PC of decoded instruction
id_rs1, id_rs2, id_rd  out  5 each  register addresses (0 when unused)
id_imm  out  XLEN  sign-extended immediate
id_alu_op  out  alu_op_t  ALU operation
id_funct3  out  3  funct3 passthrough (branch cond/load size)
id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump  out  1 each  control
id_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (async, rst_n=0): IF/ID valid=0, instr=NOP_INSTR, pc=0. All id_* outputs 0, except id_alu_op=ALU_ADD. stall_if=0.
- Latency: instruction accepted at edge N (if_valid=1, stall_if=0) appears on id_* after edge N+1 (two registers, decode combinational between them).
- Source usage:
  - R, S, B read rs1 and rs2.
  - I-type (OP-IMM, LOAD, JALR) reads rs1 only.
  - LUI, AUIPC, JAL read none; unused rs fields forced to 0.
- Load-use hazard: hazard = id_valid & id_mem_read & id_rd!=0 & (IF/ID valid) & (used rs1==id_rd | used rs2==id_rd).
- Priority per cycle: flush > ex_stall > hazard > normal.
  - flush: IF/ID valid<=0, ID/EX valid<=0 and all control<=0. stall_if=0.
  - ex_stall: IF/ID and ID/EX hold. stall_if=1.
  - hazard: IF/ID holds. ID/EX loads bubble (valid=0, control=0). stall_if=1 for exactly that cycle, so one bubble per load-use.
  - normal: IF/ID<=inputs (valid=if_valid). ID/EX<=decode of IF/ID.
- stall_if is combinational from the IF/ID register, the ID/EX register and ex_stall/flush. No dependence on if_* inputs.
- Invalid IF/ID entry decodes to a bubble: control 0, id_illegal=0.
- Illegal opcode or funct7 combination: id_valid=1, id_illegal=1, reg_write/mem_read/mem_write/branch/jump=0.
- rd=0 with reg_write: id_reg_write stays 1; x0 suppression happens in the register file. The hazard check excludes rd=0.
- Immediates, all sign-extended from the top instruction bit:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- ALU op:
  - From funct3/funct7[5] for OP and OP-IMM. SRAI uses funct7[5]; ADDI never SUB.
  - ADD for loads/stores/AUIPC/JAL/JALR, PASS_B for LUI, SUB for branches.

Decomposition:
- Package enumerations: opcode_e (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC); alu_op_t; imm_type_e (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE); NOP_INSTR constant.
- Sub-module imm_gen: combinational, inputs instr + imm_type_e, output XLEN immediate.

Test Plan:
- Reset then 0x00500093 (addi x1,x0,5) -> two edges later: id_valid=1, id_rd=1, id_rs1=0, id_imm=5, ALU_ADD, id_reg_write=1.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) -> stall_if=1 one cycle, one bubble (id_valid=0), then add with id_rs1=2, id_rs2=1, id_rd=3.
- 0xFE000CE3 (beq x0,x0,-8) -> id_imm=0xFFFFFFF8, id_branch=1, id_rd=0, id_reg_write=0. 0x123452B7 (lui x5,0x12345) -> id_imm=0x12345000, id_rs1=0.
- flush asserted together with ex_stall and a pending load-use -> next edge id_valid=0, IF/ID valid=0, stall_if=0.
- ex_stall held 3 cycles with valid entries -> id_* and IF/ID unchanged, stall_if=1 throughout. rst_n pulsed low mid-stall -> all outputs to reset values immediately.
- Opcode 0x7F (0xFFFFFFFF) -> id_valid=1, id_illegal=1, all write/mem/branch/jump controls 0.
